terminal_bank: RTL

TERMINAL_BANK -- requirements
Module: terminal_bank

---
 rtl/sat_engine_pkg.sv | 19 +
 rtl/terminal_bank_if.sv | 59 +++++
 rtl/conflict_select.sv | 34 +++
 rtl/terminal_bank.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/sat_engine_pkg.sv
// Shared SAT-engine definitions.
// FSM encoding and counter width helpers.
package sat_engine_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Bits needed to count 0..n set flags.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n channels, at least one.
  function automatic int cid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/terminal_bank_if.sv
// Clause-channel bus between the terminal bank
// and its producer/consumer.
interface terminal_bank_if
  import sat_engine_pkg::*;
#(
  parameter int NUM_C       = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_CID   = cid_w(NUM_C)
);

  localparam int CW = cnt_w(NUM_C);

  logic                         start_i;
  logic                         stop_i;
  logic                         apply_analyze_i;
  logic [NUM_C-1:0]             csat_i;
  logic [2*NUM_C-1:0]           freelitcnt_i;
  logic [WIDTH_C_LEN*NUM_C-1:0] clause_len_i;
  logic [NUM_C-1:0]             conflict_c_i;
  logic [NUM_C-1:0]             all_lit_false_i;
  logic [WIDTH_LVL*NUM_C-1:0]   cmax_lvl_i;
  logic                         conflict_ack_i;

  logic [NUM_C-1:0]             csat_drv_o;
  logic [NUM_C-1:0]             imp_drv_o;
  logic [NUM_C-1:0]             conflict_c_drv_o;
  logic [CW-1:0]                imp_cnt_o;
  logic                         all_sat_o;
  logic                         conflict_valid_o;
  logic [WIDTH_CID-1:0]         conflict_cid_o;
  logic [WIDTH_LVL-1:0]         conflict_lvl_o;
  logic [1:0]                   state_o;

  modport master (
    output start_i, stop_i, apply_analyze_i,
    output csat_i, freelitcnt_i, clause_len_i,
    output conflict_c_i, all_lit_false_i,
    output cmax_lvl_i, conflict_ack_i,
    input  csat_drv_o, imp_drv_o,
    input  conflict_c_drv_o, imp_cnt_o,
    input  all_sat_o, conflict_valid_o,
    input  conflict_cid_o, conflict_lvl_o,
    input  state_o
  );

  modport slave (
    input  start_i, stop_i, apply_analyze_i,
    input  csat_i, freelitcnt_i, clause_len_i,
    input  conflict_c_i, all_lit_false_i,
    input  cmax_lvl_i, conflict_ack_i,
    output csat_drv_o, imp_drv_o,
    output conflict_c_drv_o, imp_cnt_o,
    output all_sat_o, conflict_valid_o,
    output conflict_cid_o, conflict_lvl_o,
    output state_o
  );

endinterface

// File: rtl/conflict_select.sv
// Lowest conflicting channel and the highest
// decision level among conflicting channels.
module conflict_select #(
  parameter int NUM_C     = 8,
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_CID = (NUM_C > 1) ? $clog2(NUM_C) : 1
) (
  input  logic [NUM_C-1:0]           conf,
  input  logic [WIDTH_LVL*NUM_C-1:0] lvl,
  output logic                       conf_any,
  output logic [WIDTH_CID-1:0]       cid,
  output logic [WIDTH_LVL-1:0]       lvl_max
);

  // Scan high-to-low so the lowest hit wins.
  always_comb begin
    conf_any = |conf;
    cid      = '0;
    for (int k = NUM_C - 1; k >= 0; k--) begin
      if (conf[k]) cid = WIDTH_CID'(k);
    end
  end

  // Running maximum over conflicting channels only.
  always_comb begin
    lvl_max = '0;
    for (int k = 0; k < NUM_C; k++) begin
      if (conf[k] &&
          lvl[k*WIDTH_LVL +: WIDTH_LVL] > lvl_max)
        lvl_max = lvl[k*WIDTH_LVL +: WIDTH_LVL];
    end
  end

endmodule

// File: rtl/terminal_bank.sv
// Per-clause status registers, implication count
// and single-entry conflict latch with FSM.
module terminal_bank
  import sat_engine_pkg::*;
#(
  parameter int NUM_C       = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_CID   = cid_w(NUM_C)
) (
  input logic             clk,
  input logic             rst,
  terminal_bank_if.slave  bus
);

  localparam int CW = cnt_w(NUM_C);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [NUM_C-1:0]     act;
  logic [NUM_C-1:0]     conf_w;
  logic [NUM_C-1:0]     imp_w;
  logic [CW-1:0]        imp_sum;
  logic                 sat_w;
  logic                 sel_any;
  logic [WIDTH_CID-1:0] sel_cid;
  logic [WIDTH_LVL-1:0] sel_lvl;

  logic [NUM_C-1:0]     csat_q;
  logic [NUM_C-1:0]     imp_q;
  logic [NUM_C-1:0]     conf_q;
  logic [CW-1:0]        cnt_q;
  logic                 sat_q;
  logic                 vld_q;
  logic [WIDTH_CID-1:0] cid_q;
  logic [WIDTH_LVL-1:0] lvl_q;

  // Per-channel activity, conflict and unit flags.
  always_comb begin
    act    = '0;
    conf_w = '0;
    imp_w  = '0;
    for (int k = 0; k < NUM_C; k++) begin
      act[k] = |bus.clause_len_i[k*WIDTH_C_LEN +: WIDTH_C_LEN];
      conf_w[k] = act[k] &
        (bus.conflict_c_i[k] |
         (bus.all_lit_false_i[k] & ~bus.apply_analyze_i));
      imp_w[k] = act[k] &
        (bus.freelitcnt_i[2*k +: 2] == 2'b01) &
        ~bus.csat_i[k] & ~conf_w[k];
    end
  end

  // Implication popcount and all-active-satisfied.
  always_comb begin
    imp_sum = '0;
    sat_w   = 1'b1;
    for (int k = 0; k < NUM_C; k++) begin
      imp_sum = imp_sum + CW'(imp_w[k]);
      if (act[k] && !bus.csat_i[k]) sat_w = 1'b0;
    end
  end

  conflict_select #(
    .NUM_C     (NUM_C),
    .WIDTH_LVL (WIDTH_LVL),
    .WIDTH_CID (WIDTH_CID)
  ) u_sel (
    .conf     (conf_w),
    .lvl      (bus.cmax_lvl_i),
    .conf_any (sel_any),
    .cid      (sel_cid),
    .lvl_max  (sel_lvl)
  );

  // Next state; stop beats every other transition.
  always_comb begin
    state_nxt = state;
    if (bus.stop_i) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (1'b1)
        state == ST_IDLE:
          if (bus.start_i) state_nxt = ST_RUN;
        state == ST_RUN:
          if (sel_any) state_nxt = ST_HOLD;
        state == ST_HOLD:
          if (bus.conflict_ack_i) state_nxt = ST_RUN;
        default:
          state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Status registers track inputs unless idling.
  always_ff @(posedge clk) begin
    if (!rst || state_nxt == ST_IDLE) begin
      csat_q <= '0;
      imp_q  <= '0;
      conf_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      csat_q <= bus.csat_i;
      imp_q  <= imp_w;
      conf_q <= conf_w;
      cnt_q  <= imp_sum;
      sat_q  <= sat_w;
    end
  end

  // Conflict latch: capture on entering HOLD only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      cid_q <= '0;
      lvl_q <= '0;
    end else if (bus.stop_i) begin
      vld_q <= 1'b0;
    end else if (state == ST_RUN && sel_any) begin
      vld_q <= 1'b1;
      cid_q <= sel_cid;
      lvl_q <= sel_lvl;
    end else if (state == ST_HOLD &&
                 bus.conflict_ack_i) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.csat_drv_o       = csat_q;
  assign bus.imp_drv_o        = imp_q;
  assign bus.conflict_c_drv_o = conf_q;
  assign bus.imp_cnt_o        = cnt_q;
  assign bus.all_sat_o        = sat_q;
  assign bus.conflict_valid_o = vld_q;
  assign bus.conflict_cid_o   = cid_q;
  assign bus.conflict_lvl_o   = lvl_q;
  assign bus.state_o          = state;

endmodule
